// File: rtl/s_transform_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : s_transform_pipe
//  Purpose  : Two-stage valid/ready pipeline that substitutes every SYM_W-bit
//             lane of a word through a run-time loadable table T. A small key
//             FSM loads a new table, checks that it is a permutation and only
//             then commits it. A rejected load leaves T unchanged and raises
//             the sticky Key_Err flag.
//  Ports    : Clk, Rst (async, active-high)
//             In_Valid/In_Ready/In_Data     - input word stream
//             Out_Valid/Out_Ready/Out_Data  - substituted word stream
//             Key_Start/Key_Valid/Key_Data  - key-load request and entries
//             Key_Busy/Key_Err              - load in progress / last load bad
//             Inv                           - select inverse table (only when
//                                             S_INVERSE_EN is defined)
//  Options  : `define S_INVERSE_EN adds the Inv port and the inverse table.
//  Revision : 1.0 - initial release
// ============================================================================
module s_transform_pipe #(
    parameter int LANES = 4,
    parameter int SYM_W = 2
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [LANES*SYM_W-1:0] In_Data,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [LANES*SYM_W-1:0] Out_Data,
    input  logic                   Key_Start,
    input  logic                   Key_Valid,
    input  logic [SYM_W-1:0]       Key_Data,
    output logic                   Key_Busy,
`ifdef S_INVERSE_EN
    input  logic                   Inv,
`endif
    output logic                   Key_Err
);

    localparam int               c_DEPTH = 1 << SYM_W;
    localparam logic [SYM_W-1:0] c_HALF  = SYM_W'(1) << (SYM_W - 1);
    localparam logic [SYM_W-1:0] c_LAST  = SYM_W'(c_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } key_state_t;

    // Tables are packed: entry v lives at [v*SYM_W +: SYM_W].
    logic [c_DEPTH*SYM_W-1:0] r_tbl;
    logic [c_DEPTH*SYM_W-1:0] r_shadow;
    logic [c_DEPTH-1:0]       r_seen;
    logic                     r_dup;
    logic [SYM_W-1:0]         r_idx;
    key_state_t               r_state;
    logic                     r_key_busy;
    logic                     r_key_err;

    logic                     r_a_valid;
    logic [LANES*SYM_W-1:0]   r_a_data;
    logic                     r_b_valid;
    logic [LANES*SYM_W-1:0]   r_b_data;

    logic                     w_b_adv;
    logic                     w_a_adv;
    logic                     w_in_ready;
    logic                     w_in_fire;
    logic [LANES*SYM_W-1:0]   w_sub;

`ifdef S_INVERSE_EN
    logic [c_DEPTH*SYM_W-1:0] r_inv;
    logic [c_DEPTH*SYM_W-1:0] w_inv_new;
    logic                     r_a_inv;

    // Inverse of the shadow table; only meaningful once the shadow has been
    // proven to be a permutation, which is the only time it is committed.
    always_comb begin
        w_inv_new = '0;
        for (int v = 0; v < c_DEPTH; v++) begin
            w_inv_new[r_shadow[v*SYM_W +: SYM_W]*SYM_W +: SYM_W] = SYM_W'(v);
        end
    end
`endif

    // B advances when empty or draining; A moves into B whenever B advances.
    assign w_b_adv    = !r_b_valid || Out_Ready;
    assign w_a_adv    = r_a_valid && w_b_adv;
    // Input is held off during a key load and while a load request waits for
    // the pipeline to drain.
    assign w_in_ready = !r_key_busy && !Key_Start && (!r_a_valid || w_b_adv);
    assign w_in_fire  = In_Valid && w_in_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SYM_W-1:0] w_sym;
            assign w_sym = r_a_data[gi*SYM_W +: SYM_W];
`ifdef S_INVERSE_EN
            assign w_sub[gi*SYM_W +: SYM_W] = r_a_inv ? r_inv[w_sym*SYM_W +: SYM_W]
                                                      : r_tbl[w_sym*SYM_W +: SYM_W];
`else
            assign w_sub[gi*SYM_W +: SYM_W] = r_tbl[w_sym*SYM_W +: SYM_W];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath: stage A holds the raw word, stage B the substituted word.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
`ifdef S_INVERSE_EN
            r_a_inv   <= 1'b0;
`endif
        end else begin
            if (w_in_fire) begin
                r_a_valid <= 1'b1;
                r_a_data  <= In_Data;
`ifdef S_INVERSE_EN
                r_a_inv   <= Inv;
`endif
            end else if (w_a_adv) begin
                r_a_valid <= 1'b0;
            end

            if (w_b_adv) begin
                r_b_valid <= r_a_valid;
                if (r_a_valid) begin
                    r_b_data <= w_sub;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Key load FSM and table storage.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= ST_IDLE;
            r_key_busy <= 1'b0;
            r_key_err  <= 1'b0;
            r_idx      <= '0;
            r_seen     <= '0;
            r_dup      <= 1'b0;
            r_shadow   <= '0;
            // Default map flips the symbol MSB; it is its own inverse.
            for (int v = 0; v < c_DEPTH; v++) begin
                r_tbl[v*SYM_W +: SYM_W] <= SYM_W'(v) ^ c_HALF;
`ifdef S_INVERSE_EN
                r_inv[v*SYM_W +: SYM_W] <= SYM_W'(v) ^ c_HALF;
`endif
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Table may only change with no word in flight.
                    if (Key_Start && !r_a_valid && !r_b_valid) begin
                        r_state    <= ST_LOAD;
                        r_key_busy <= 1'b1;
                        r_idx      <= '0;
                        r_seen     <= '0;
                        r_dup      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (Key_Valid) begin
                        r_shadow[r_idx*SYM_W +: SYM_W] <= Key_Data;
                        r_seen[Key_Data]               <= 1'b1;
                        if (r_seen[Key_Data]) begin
                            r_dup <= 1'b1;
                        end
                        r_idx <= r_idx + SYM_W'(1);
                        if (r_idx == c_LAST) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    r_state    <= ST_IDLE;
                    r_key_busy <= 1'b0;
                    if ((&r_seen) && !r_dup) begin
                        r_tbl     <= r_shadow;
`ifdef S_INVERSE_EN
                        r_inv     <= w_inv_new;
`endif
                        r_key_err <= 1'b0;
                    end else begin
                        r_key_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_key_busy <= 1'b0;
                end
            endcase
        end
    end

    assign In_Ready  = w_in_ready;
    assign Out_Valid = r_b_valid;
    assign Out_Data  = r_b_data;
    assign Key_Busy  = r_key_busy;
    assign Key_Err   = r_key_err;

endmodule
`default_nettype wire

// File: tb/tb_s_transform_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s_transform_pipe
//  Purpose  : Self-checking bench for s_transform_pipe (LANES=4, SYM_W=2).
//             Random traffic is scored against a table-lookup model; key loads
//             are judged by counting symbol occurrences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_s_transform_pipe;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] In_Data = '0;
    logic       Out_Valid;
    logic       Out_Ready = 1'b0;
    logic [7:0] Out_Data;
    logic       Key_Start = 1'b0;
    logic       Key_Valid = 1'b0;
    logic [1:0] Key_Data = '0;
    logic       Key_Busy;
    logic       Key_Err;
    logic       inv_drv = 1'b0;

`ifdef S_INVERSE_EN
    localparam bit c_INV_EN = 1'b1;
`else
    localparam bit c_INV_EN = 1'b0;
`endif

    s_transform_pipe #(.LANES(4), .SYM_W(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Data   (In_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Data  (Out_Data),
        .Key_Start (Key_Start),
        .Key_Valid (Key_Valid),
        .Key_Data  (Key_Data),
        .Key_Busy  (Key_Busy),
`ifdef S_INVERSE_EN
        .Inv       (inv_drv),
`endif
        .Key_Err   (Key_Err)
    );

    always #5 Clk = ~Clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         mt[4];
    bit         m_err;
    logic [7:0] exp_q[$];
    bit         hold_pending = 1'b0;
    logic [7:0] hold_data;

    logic       s_in_ready, s_out_valid, s_key_busy, s_key_err;
    logic [7:0] s_out_data;
    int         s_qsize;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rbit(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Lane-wise lookup; the inverse is found by searching the forward table.
    function automatic logic [7:0] model_word(input logic [7:0] d, input bit inv);
        logic [7:0] r;
        int x, y;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = int'(d[i*2 +: 2]);
            y = mt[x];
            if (inv) begin
                for (int v = 0; v < 4; v++) if (mt[v] == x) y = v;
            end
            r[i*2 +: 2] = 2'(y);
        end
        return r;
    endfunction

    function automatic bit is_perm(input int k[4]);
        int cnt[4];
        for (int v = 0; v < 4; v++) cnt[v] = 0;
        for (int i = 0; i < 4; i++) cnt[k[i]]++;
        for (int v = 0; v < 4; v++) if (cnt[v] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: drive after the falling edge, sample and score before
    // the next rising edge.
    task automatic step(input bit iv, input logic [7:0] d, input bit ordy,
                        input bit ks, input bit kv, input logic [1:0] kd,
                        input bit inv);
        logic [7:0] e;
        @(negedge Clk);
        In_Valid = iv; In_Data = d; Out_Ready = ordy;
        Key_Start = ks; Key_Valid = kv; Key_Data = kd; inv_drv = inv;
        #1;
        s_in_ready = In_Ready; s_out_valid = Out_Valid; s_out_data = Out_Data;
        s_key_busy = Key_Busy; s_key_err = Key_Err; s_qsize = exp_q.size();
        if (hold_pending) begin
            check("hold_valid", int'(Out_Valid), 1);
            check("hold_data", int'(Out_Data), int'(hold_data));
        end
        hold_pending = Out_Valid && !Out_Ready;
        hold_data    = Out_Data;
        if (Key_Start || Key_Busy) check("in_ready_gated", int'(In_Ready), 0);
        if (Out_Valid && Out_Ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", int'(Out_Valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", int'(Out_Data), int'(e));
            end
        end
        if (In_Valid && In_Ready) exp_q.push_back(model_word(In_Data, inv && c_INV_EN));
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
        Key_Start = 1'b0; Key_Valid = 1'b0;
        #1;
        check("rst_out_valid", int'(Out_Valid), 0);
        check("rst_out_data", int'(Out_Data), 0);
        check("rst_key_busy", int'(Key_Busy), 0);
        check("rst_key_err", int'(Key_Err), 0);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        exp_q.delete();
        hold_pending = 1'b0;
        for (int v = 0; v < 4; v++) mt[v] = v ^ 2;
        m_err = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step(0, 8'h00, 1, 0, 0, 2'd0, 0);
        check("drain_left", exp_q.size(), 0);
    endtask

    // Word presented in cycle k must be on the output in cycle k+2.
    task automatic send_check(input logic [7:0] d, input logic [7:0] exp, input bit inv,
                              input string tag);
        drain();
        step(1, d, 1, 0, 0, 2'd0, inv);
        check("send_accept", int'(s_in_ready), 1);
        step(0, 8'h00, 1, 0, 0, 2'd0, 0);
        check("lat_early", int'(s_out_valid), 0);
        step(0, 8'h00, 1, 0, 0, 2'd0, 0);
        check("lat_valid", int'(s_out_valid), 1);
        check(tag, int'(s_out_data), int'(exp));
    endtask

    task automatic traffic(input int n);
        for (int c = 0; c < n; c++)
            step(rbit(75), 8'($urandom), rbit(70), 0, rbit(12), 2'($urandom), rbit(50));
        drain();
    endtask

    // Loads the first n entries of k; with n<4 the load is left open.
    task automatic load_key(input int k[4], input int n);
        int busy_n;
        bit started;
        busy_n = 0;
        started = 1'b0;
        for (int t = 0; t < 40 && !started; t++) begin
            step(rbit(50), 8'($urandom), 1, 1, 0, 2'd0, 0);
            if (s_qsize == 0) started = 1'b1;
        end
        check("load_start", int'(started), 1);
        for (int i = 0; i < n; i++) begin
            step(rbit(50), 8'($urandom), 1, rbit(50), 1, 2'(k[i]), 0);
            busy_n += int'(s_key_busy);
        end
        if (n < 4) return;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 0, rbit(50), 2'($urandom), 0);
            busy_n += int'(s_key_busy);
        end
        check("key_busy_cycles", busy_n, 5);
        if (is_perm(k)) begin
            for (int v = 0; v < 4; v++) mt[v] = k[v];
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        check("key_err", int'(s_key_err), int'(m_err));
    endtask

    task automatic stall_test();
        int  acc;
        bit  taken;
        logic [7:0] w0, w1, w2;
        w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
        acc = 0;
        taken = 1'b0;
        drain();
        step(1, w0, 0, 0, 0, 2'd0, 0); acc += int'(s_in_ready);
        step(1, w1, 0, 0, 0, 2'd0, 0); acc += int'(s_in_ready);
        step(1, w2, 0, 0, 0, 2'd0, 0); acc += int'(s_in_ready);
        check("stall_in_ready", int'(s_in_ready), 0);
        check("stall_out_data", int'(s_out_data), int'(model_word(w0, 1'b0)));
        step(1, w2, 0, 0, 0, 2'd0, 0); acc += int'(s_in_ready);
        check("stall_accepted", acc, 2);
        for (int t = 0; t < 10 && !taken; t++) begin
            step(1, w2, 1, 0, 0, 2'd0, 0);
            if (s_in_ready) taken = 1'b1;
        end
        check("stall_w2_taken", int'(taken), 1);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int key[4];
        int j, tmp;
        do_reset();
        send_check(8'hB4, 8'h1E, 0, "fwd_default");
        traffic(300);
        stall_test();

        key = '{3, 2, 1, 0};
        load_key(key, 4);
        send_check(8'h1B, 8'hE4, 0, "fwd_key3210");
        traffic(200);

        do_reset();
        key = '{0, 0, 1, 2};
        load_key(key, 4);
        send_check(8'hB4, 8'h1E, 0, "fwd_after_bad_key");
        traffic(100);
        check("key_err_sticky", int'(s_key_err), int'(m_err));

        for (int r = 0; r < 6; r++) begin
            if (rbit(60)) begin
                key = '{0, 1, 2, 3};
                for (int i = 3; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    tmp = key[i]; key[i] = key[j]; key[j] = tmp;
                end
            end else begin
                for (int i = 0; i < 4; i++) key[i] = $urandom_range(0, 3);
            end
            load_key(key, 4);
            traffic(120);
        end

`ifdef S_INVERSE_EN
        key = '{1, 2, 3, 0};
        load_key(key, 4);
        send_check(8'h1B, 8'hC6, 1, "inv_sel");
        send_check(8'h1B, 8'h6C, 0, "fwd_sel");
        traffic(150);
`endif

        key = '{3, 1, 0, 2};
        load_key(key, 2);
        check("abort_busy_mid_load", int'(s_key_busy), 1);
        do_reset();
        step(0, 8'h00, 1, 0, 0, 2'd0, 0);
        check("abort_busy_after_rst", int'(s_key_busy), 0);
        send_check(8'hB4, 8'h1E, 0, "fwd_after_abort");
        traffic(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
